// File: rtl/pkg_mult.sv
// Shared types for the sequential shift-add multiplier: FSM encoding,
// operand/product widths and the datapath register bundle.
package pkg_mult;

  // Operand width of the multiplier. The top-level WIDTH parameter defaults
  // to this value and must stay equal to it, because the packed types below
  // are sized from it.
  localparam int DATA_W = 8;

  typedef logic [DATA_W-1:0]   data_t;
  typedef logic [2*DATA_W-1:0] product_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } mult_state_t;

  // Working registers of the shift-add loop:
  // a - shifted multiplicand, b - remaining multiplier bits, p - partial sum.
  typedef struct packed {
    product_t a;
    data_t    b;
    product_t p;
  } dp_regs_t;

  // Zero-extend an operand to product width.
  function automatic product_t widen(input data_t x);
    return {{DATA_W{1'b0}}, x};
  endfunction

endpackage

// File: rtl/mult_shift_add_dp.sv
// Shift-add datapath: holds the multiplicand/multiplier/partial-product
// registers and performs one load or one iteration per cycle on command.
module mult_shift_add_dp
  import pkg_mult::*;
(
  input  logic     i_clk,
  input  logic     i_rst,
  input  logic     i_ctrl_load,
  input  logic     i_ctrl_step,
  input  data_t    i_multiplier,
  input  data_t    i_multiplicand,
  output product_t o_p_next
);

  dp_regs_t regs_q;
  dp_regs_t regs_d;
  product_t addend;

  // Partial product after the current iteration; the controller captures
  // this on the final step so the result is visible alongside o_done.
  assign addend   = regs_q.b[0] ? regs_q.a : '0;
  assign o_p_next = regs_q.p + addend;

  // Next-state of the working registers: load has priority over step.
  always_comb begin
    // NOTE: every combinational output gets a default first, otherwise a
    // path that skips the assignment infers a latch.
    regs_d = regs_q;
    if (i_ctrl_load) begin
      regs_d.a = widen(i_multiplicand);
      regs_d.b = i_multiplier;
      regs_d.p = '0;
    end else if (i_ctrl_step) begin
      regs_d.p = o_p_next;
      regs_d.a = regs_q.a << 1;
      regs_d.b = regs_q.b >> 1;
    end
  end

  // Working registers with synchronous active-low clear.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    if (!i_rst) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencing controller for the unsigned shift-add multiplier: start edge
// detection, IDLE/LOAD/CALC/DONE FSM, iteration counter and registered
// product/busy/done outputs.
module mult_seq_ctrl
  import pkg_mult::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_multiplier,
  input  logic [WIDTH-1:0]   i_multiplicand,
  output logic [2*WIDTH-1:0] o_product,
  output logic               o_busy,
  output logic               o_done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  mult_state_t        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               start_hist_q;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               start_pulse;
  logic               last_iter;
  logic               ctrl_load;
  logic               ctrl_step;
  product_t           dp_p_next;

  // Rising edge of the start button; the history register resets to 1 so a
  // button held through reset cannot launch an operation.
  assign start_pulse = i_start & ~start_hist_q;
  assign last_iter   = (cnt_q == CNT_W'(WIDTH - 1));

  mult_shift_add_dp u_dp (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_ctrl_load    (ctrl_load),
    .i_ctrl_step    (ctrl_step),
    .i_multiplier   (i_multiplier),
    .i_multiplicand (i_multiplicand),
    .o_p_next       (dp_p_next)
  );

  // FSM next state, counter, datapath commands and output next values.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    ctrl_load = 1'b0;
    ctrl_step = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_pulse) state_d = LOAD;
      end
      LOAD: begin
        ctrl_load = 1'b1;
        cnt_d     = '0;
        state_d   = CALC;
      end
      CALC: begin
        ctrl_step = 1'b1;
        cnt_d     = cnt_q + CNT_W'(1);
        if (last_iter) begin
          // Capture the final sum now so o_product and o_done appear together.
          product_d = dp_p_next;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == LOAD) || (state_d == CALC);
    done_d = (state_d == DONE);
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      start_hist_q <= 1'b1;
      product_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      start_hist_q <= i_start;
      product_q    <= product_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign o_product = product_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed self-checking bench for mult_seq_ctrl (WIDTH = 8).
module tb_mult_seq_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_start = 1'b0;
  logic [7:0]  i_multiplier = '0;
  logic [7:0]  i_multiplicand = '0;
  logic [15:0] o_product;
  logic        o_busy;
  logic        o_done;

  int checks = 0;
  int errors = 0;

  mult_seq_ctrl #(.WIDTH(8)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_start        (i_start),
    .i_multiplier   (i_multiplier),
    .i_multiplicand (i_multiplicand),
    .o_product      (o_product),
    .o_busy         (o_busy),
    .o_done         (o_done)
  );

  always #5 i_clk = ~i_clk;

  // Advance one rising edge, then settle before sampling or driving.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Launch one operation and watch a 32-edge window.
  // hold    : number of edges i_start stays high (>= 1)
  // poke_at : edge index at which a second start pulse with 3*3 operands is
  //           applied during the run (0 = none)
  task automatic run_op(input logic [7:0] mr, input logic [7:0] md, input int hold,
                        input int poke_at, input logic [15:0] exp_p, input string tag);
    int busy_cnt;
    int done_cnt;
    int first_done;
    i_multiplier   = mr;
    i_multiplicand = md;
    i_start        = 1'b1;
    step();                       // edge k: start sampled, LOAD follows
    busy_cnt   = int'(o_busy);
    done_cnt   = int'(o_done);
    first_done = 0;
    for (int n = 2; n <= 32; n++) begin
      i_start = (n <= hold) ? 1'b1 : 1'b0;
      if (poke_at != 0 && n == poke_at) begin
        i_start        = 1'b1;
        i_multiplier   = 8'd3;
        i_multiplicand = 8'd3;
      end
      step();
      busy_cnt += int'(o_busy);
      if (o_done) begin
        done_cnt++;
        if (first_done == 0) first_done = n;
      end
    end
    i_start = 1'b0;
    step();
    check({tag, "_done_latency"}, 32'(first_done), 32'd10);
    check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd9);
    check({tag, "_product"}, 32'(o_product), 32'(exp_p));
    check({tag, "_idle_busy"}, 32'(o_busy), 32'd0);
  endtask

  initial begin
    int seen;

    // Reset held for three edges with the button pressed.
    i_rst   = 1'b0;
    i_start = 1'b1;
    repeat (3) step();
    check("rst_product", 32'(o_product), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);

    // Release reset with the button still held: nothing may start.
    i_rst = 1'b1;
    seen  = 0;
    for (int n = 0; n < 14; n++) begin
      step();
      seen += int'(o_busy) + int'(o_done);
    end
    check("rst_held_no_op", 32'(seen), 32'd0);
    check("rst_held_product", 32'(o_product), 32'd0);
    i_start = 1'b0;
    step();

    // Basic and extreme operands.
    run_op(8'd13,  8'd11,  1, 0, 16'd143,   "basic_13x11");
    run_op(8'd255, 8'd255, 1, 0, 16'hFE01,  "max_255x255");
    run_op(8'd0,   8'd200, 1, 0, 16'd0,     "zero_0x200");
    run_op(8'd1,   8'd255, 1, 0, 16'd255,   "one_1x255");

    // Button held for 30 cycles: one operation only, then a fresh press.
    run_op(8'd6, 8'd7, 30, 0, 16'd42, "held_6x7");
    run_op(8'd5, 8'd5, 1,  0, 16'd25, "second_5x5");

    // Second press and operand change during CALC are ignored.
    run_op(8'd9, 8'd9, 1, 4, 16'd81, "busy_9x9");

    // Reset in the 4th CALC cycle.
    i_multiplier   = 8'd200;
    i_multiplicand = 8'd100;
    i_start        = 1'b1;
    step();                       // edge k -> LOAD
    i_start = 1'b0;
    repeat (4) step();            // LOAD->CALC, then three more CALC cycles
    check("midrst_busy_before", 32'(o_busy), 32'd1);
    i_rst = 1'b0;
    step();
    check("midrst_product", 32'(o_product), 32'd0);
    check("midrst_busy", 32'(o_busy), 32'd0);
    check("midrst_done", 32'(o_done), 32'd0);
    i_rst = 1'b1;
    seen  = 0;
    for (int n = 0; n < 14; n++) begin
      step();
      seen += int'(o_done) + int'(o_busy);
    end
    check("midrst_no_done", 32'(seen), 32'd0);
    run_op(8'd2, 8'd3, 1, 0, 16'd6, "after_rst_2x3");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
